// File: rtl/stage_m_if.sv
// Data-bus handshake between the memory stage (master) and data memory / devices (slave).
interface stage_m_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/stage_m.sv
// Memory stage: E/M pipeline register, load/store address checks, req/ack data-bus
// sequencing with a no-ack timeout, byte enables and extended load data.
module stage_m #(
  parameter logic [31:0] DM_TOP  = 32'h0000_2FFF,
  parameter logic [31:0] DEV_LO  = 32'h0000_7F00,
  parameter logic [31:0] DEV_HI  = 32'h0000_7F1B,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] C_E,
  input  logic [31:0] RD2_E,
  input  logic [6:2]  ExcCodeE,
  input  logic [3:0]  MemOp_E,
  input  logic [4:0]  RFWA_E,
  input  logic [31:0] PC_E,
  stage_m_if.master   bus,
  output logic        busy,
  output logic [31:0] C_M,
  output logic [31:0] LD_M,
  output logic [6:2]  ExcCodeM,
  output logic [4:0]  RFWA_M,
  output logic [31:0] PC_M
);

  typedef enum logic [3:0] {
    OP_NONE = 4'd0, OP_LW = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3, OP_LB = 4'd4,
    OP_LBU  = 4'd5, OP_SW = 4'd6, OP_SH = 4'd7, OP_SB  = 4'd8
  } mem_op_e;

  // S_DBE is the single cycle after the timeout expires: request dropped, DBE reported.
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DBE} state_e;

  localparam logic [6:2] EXC_NONE = 5'd0;
  localparam logic [6:2] EXC_ADEL = 5'd4;
  localparam logic [6:2] EXC_ADES = 5'd5;
  localparam logic [6:2] EXC_DBE  = 5'd7;
  localparam int CW = $clog2(TIMEOUT + 1);

  function automatic logic is_load(input mem_op_e op);
    return op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return op inside {OP_SW, OP_SH, OP_SB};
  endfunction

  // An upstream exception always takes precedence over the address checks.
  function automatic logic [6:2] check_exc(input logic [6:2] exc_in, input mem_op_e op,
                                           input logic [31:0] addr);
    logic mis;
    logic in_range;
    if (exc_in != EXC_NONE) return exc_in;
    in_range = (addr <= DM_TOP) || ((addr >= DEV_LO) && (addr <= DEV_HI));
    case (op)
      OP_LW, OP_SW:          mis = (addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH:  mis = addr[0];
      default:               mis = 1'b0;
    endcase
    if (is_load(op) && (mis || !in_range))  return EXC_ADEL;
    if (is_store(op) && (mis || !in_range)) return EXC_ADES;
    return EXC_NONE;
  endfunction

  mem_op_e        op_e;
  mem_op_e        op_q;
  state_e         state;
  logic [CW-1:0]  cnt;
  logic [31:0]    rd2_q;
  logic [6:2]     exc_q;
  logic [6:2]     addr_exc;
  logic [4:0]     rfwa_q;
  logic           flush_pend;
  logic           dbe_q;
  logic           flush_eff;
  logic           start;

  assign op_e      = mem_op_e'(MemOp_E);
  assign busy      = (state == S_ACCESS) && !bus.mem_ack;
  assign flush_eff = flush || flush_pend;
  assign start     = !flush_eff && !stall && is_load(op_e) | is_store(op_e)
                     && (check_exc(ExcCodeE, op_e, C_E) == EXC_NONE);
  assign addr_exc  = check_exc(exc_q, op_q, C_M);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      C_M        <= '0;
      rd2_q      <= '0;
      exc_q      <= EXC_NONE;
      op_q       <= OP_NONE;
      rfwa_q     <= '0;
      PC_M       <= '0;
      flush_pend <= 1'b0;
      dbe_q      <= 1'b0;
    end else begin
      flush_pend <= busy && flush_eff;
      if (!busy) begin
        if (flush_eff) begin
          C_M    <= '0;
          rd2_q  <= '0;
          exc_q  <= EXC_NONE;
          op_q   <= OP_NONE;
          rfwa_q <= '0;
          PC_M   <= '0;
          dbe_q  <= 1'b0;
        end else if (stall) begin
          // A held instruction that just timed out must keep reporting DBE.
          if (state == S_DBE) dbe_q <= 1'b1;
        end else begin
          C_M    <= C_E;
          rd2_q  <= RD2_E;
          exc_q  <= ExcCodeE;
          op_q   <= op_e;
          rfwa_q <= RFWA_E;
          PC_M   <= PC_E;
          dbe_q  <= 1'b0;
        end
        state <= start ? S_ACCESS : S_IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
        if (cnt == CW'(TIMEOUT - 1)) state <= S_DBE;
      end
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    ExcCodeM = EXC_NONE;
    if (addr_exc != EXC_NONE)               ExcCodeM = addr_exc;
    else if (dbe_q || (state == S_DBE))     ExcCodeM = EXC_DBE;
    RFWA_M = (ExcCodeM != EXC_NONE || flush_pend) ? 5'd0 : rfwa_q;
  end

  always_comb begin
    bus.mem_req   = (state == S_ACCESS);
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_be    = '0;
    bus.mem_wdata = '0;
    if (state == S_ACCESS) begin
      bus.mem_addr = {C_M[31:2], 2'b00};
      bus.mem_we   = is_store(op_q);
      case (op_q)
        OP_LW, OP_SW:          bus.mem_be = 4'b1111;
        OP_LH, OP_LHU, OP_SH:  bus.mem_be = C_M[1] ? 4'b1100 : 4'b0011;
        OP_LB, OP_LBU, OP_SB:  bus.mem_be = 4'b0001 << C_M[1:0];
        default:               bus.mem_be = 4'b0000;
      endcase
      case (op_q)
        OP_SW:   bus.mem_wdata = rd2_q;
        OP_SH:   bus.mem_wdata = {2{rd2_q[15:0]}};
        OP_SB:   bus.mem_wdata = {4{rd2_q[7:0]}};
        default: bus.mem_wdata = '0;
      endcase
    end
  end

  logic [15:0] half;
  logic [7:0]  byte_lane;

  always_comb begin
    half = C_M[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (C_M[1:0])
      2'd0:    byte_lane = bus.mem_rdata[7:0];
      2'd1:    byte_lane = bus.mem_rdata[15:8];
      2'd2:    byte_lane = bus.mem_rdata[23:16];
      default: byte_lane = bus.mem_rdata[31:24];
    endcase
    LD_M = '0;
    // Data a pending flush will squash is never presented to writeback.
    if ((state == S_ACCESS) && bus.mem_ack && !flush_pend) begin
      case (op_q)
        OP_LW:   LD_M = bus.mem_rdata;
        OP_LH:   LD_M = {{16{half[15]}}, half};
        OP_LHU:  LD_M = {16'h0000, half};
        OP_LB:   LD_M = {{24{byte_lane[7]}}, byte_lane};
        OP_LBU:  LD_M = {24'h00_0000, byte_lane};
        default: LD_M = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_m.sv
// Directed bench for stage_m: loads, stores, address exceptions, flush-while-busy,
// stall hold, bus timeout and asynchronous reset during an access.
module tb_stage_m;
  localparam logic [3:0] NONE = 4'd0, LW = 4'd1, LH = 4'd2, LHU = 4'd3, LB = 4'd4,
                         LBU = 4'd5, SW = 4'd6, SH = 4'd7, SB = 4'd8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] C_E = '0, RD2_E = '0, PC_E = '0;
  logic [6:2]  ExcCodeE = '0;
  logic [3:0]  MemOp_E = '0;
  logic [4:0]  RFWA_E = '0;
  logic        busy;
  logic [31:0] C_M, LD_M, PC_M;
  logic [6:2]  ExcCodeM;
  logic [4:0]  RFWA_M;
  int          checks = 0;
  int          fails = 0;

  stage_m_if bus();

  stage_m dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .C_E(C_E), .RD2_E(RD2_E), .ExcCodeE(ExcCodeE), .MemOp_E(MemOp_E),
    .RFWA_E(RFWA_E), .PC_E(PC_E), .bus(bus),
    .busy(busy), .C_M(C_M), .LD_M(LD_M), .ExcCodeM(ExcCodeM),
    .RFWA_M(RFWA_M), .PC_M(PC_M)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_e(input logic [3:0] op, input logic [31:0] c, input logic [31:0] d,
                       input logic [6:2] exc, input logic [4:0] rd, input logic [31:0] pc);
    MemOp_E = op; C_E = c; RD2_E = d; ExcCodeE = exc; RFWA_E = rd; PC_E = pc;
  endtask

  task automatic test_reset();
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    set_e(LW, 32'h10, 32'h0, 5'd0, 5'd3, 32'h100);
    step();
    if ({busy, bus.mem_req, bus.mem_we, bus.mem_be, ExcCodeM, RFWA_M} !== '0 ||
        {C_M, PC_M, LD_M, bus.mem_addr, bus.mem_wdata} !== '0) begin
      $display("FAIL reset_outputs: req=%b busy=%b C_M=%h PC_M=%h exc=%0d expected all zero",
               bus.mem_req, busy, C_M, PC_M, ExcCodeM);
      fails++;
    end
    checks++;
    set_e(NONE, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step();
    if (bus.mem_req !== 1'b0 || C_M !== 32'h0) begin
      $display("FAIL reset_release: req=%b C_M=%h expected 0/0", bus.mem_req, C_M);
      fails++;
    end
    checks++;
  endtask

  task automatic test_lw();
    set_e(LW, 32'h10, 32'h0, 5'd0, 5'd3, 32'h100);
    step();
    set_e(NONE, 0, 0, 0, 0, 0);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    #1;
    if (bus.mem_req !== 1'b1 || bus.mem_be !== 4'b1111 || bus.mem_we !== 1'b0 ||
        bus.mem_addr !== 32'h10) begin
      $display("FAIL lw_bus: req=%b be=%b we=%b addr=%h expected 1/1111/0/00000010",
               bus.mem_req, bus.mem_be, bus.mem_we, bus.mem_addr);
      fails++;
    end
    checks++;
    if (busy !== 1'b0) begin $display("FAIL lw_busy: got %b expected 0", busy); fails++; end
    checks++;
    if (LD_M !== 32'hDEAD_BEEF) begin
      $display("FAIL lw_data: got %h expected deadbeef", LD_M); fails++;
    end
    checks++;
    if (RFWA_M !== 5'd3 || PC_M !== 32'h100 || ExcCodeM !== 5'd0) begin
      $display("FAIL lw_regs: rfwa=%0d pc=%h exc=%0d expected 3/00000100/0", RFWA_M, PC_M, ExcCodeM);
      fails++;
    end
    checks++;
    step();
    bus.mem_ack = 1'b0;
    #1;
    if (bus.mem_req !== 1'b0) begin
      $display("FAIL lw_req_one_cycle: got %b expected 0", bus.mem_req); fails++;
    end
    checks++;
  endtask

  task automatic test_load_ext();
    logic [3:0]  ops  [5] = '{LB, LBU, LH, LHU, LB};
    logic [31:0] adrs [5] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10};
    logic [31:0] exps [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_FF7F, 32'h0000_007F};
    logic [3:0]  bes  [5] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      set_e(ops[i], adrs[i], 32'h0, 5'd0, 5'd4, 32'h104);
      step();
      set_e(NONE, 0, 0, 0, 0, 0);
      bus.mem_ack = 1'b1;
      bus.mem_rdata = 32'h80FF_FF7F;
      #1;
      if (LD_M !== exps[i]) begin
        $display("FAIL load_ext[%0d]: LD_M=%h expected %h", i, LD_M, exps[i]); fails++;
      end
      checks++;
      if (bus.mem_be !== bes[i] || bus.mem_addr !== 32'h10) begin
        $display("FAIL load_be[%0d]: be=%b addr=%h expected %b/00000010", i, bus.mem_be,
                 bus.mem_addr, bes[i]);
        fails++;
      end
      checks++;
      step();
      bus.mem_ack = 1'b0;
    end
  endtask

  task automatic test_store();
    set_e(SH, 32'h2, 32'h1234_ABCD, 5'd0, 5'd0, 32'h200);
    step();
    set_e(NONE, 0, 0, 0, 0, 0);
    #1;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_be !== 4'b1100 ||
        bus.mem_wdata !== 32'hABCD_ABCD || bus.mem_addr !== 32'h0 || busy !== 1'b1) begin
      $display("FAIL sh_bus: req=%b we=%b be=%b wdata=%h addr=%h busy=%b expected 1/1/1100/abcdabcd/0/1",
               bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_wdata, bus.mem_addr, busy);
      fails++;
    end
    checks++;
    step();
    bus.mem_ack = 1'b1;
    #1;
    if (busy !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_wdata !== 32'hABCD_ABCD) begin
      $display("FAIL sh_ack: busy=%b req=%b wdata=%h expected 0/1/abcdabcd", busy, bus.mem_req,
               bus.mem_wdata);
      fails++;
    end
    checks++;
    step();
    bus.mem_ack = 1'b0;
    set_e(SB, 32'h7F1B, 32'h0000_00EE, 5'd0, 5'd0, 32'h204);
    step();
    set_e(NONE, 0, 0, 0, 0, 0);
    bus.mem_ack = 1'b1;
    #1;
    if (bus.mem_req !== 1'b1 || bus.mem_be !== 4'b1000 || bus.mem_wdata !== 32'hEEEE_EEEE ||
        bus.mem_addr !== 32'h7F18) begin
      $display("FAIL sb_dev_top: req=%b be=%b wdata=%h addr=%h expected 1/1000/eeeeeeee/00007f18",
               bus.mem_req, bus.mem_be, bus.mem_wdata, bus.mem_addr);
      fails++;
    end
    checks++;
    step();
    bus.mem_ack = 1'b0;
    set_e(SH, 32'h3, 32'h1234_ABCD, 5'd0, 5'd6, 32'h208);
    step();
    set_e(NONE, 0, 0, 0, 0, 0);
    #1;
    if (ExcCodeM !== 5'd5 || bus.mem_req !== 1'b0 || busy !== 1'b0 || RFWA_M !== 5'd0) begin
      $display("FAIL sh_misaligned: exc=%0d req=%b busy=%b rfwa=%0d expected 5/0/0/0",
               ExcCodeM, bus.mem_req, busy, RFWA_M);
      fails++;
    end
    checks++;
    step();
  endtask

  task automatic test_range();
    logic [3:0]  ops  [6] = '{LW, LW, LW, LB, SW, LW};
    logic [31:0] adrs [6] = '{32'h4000, 32'h2, 32'h2FFC, 32'h3000, 32'h7EFC, 32'h7F18};
    logic [6:2]  excs [6] = '{5'd0, 5'd12, 5'd0, 5'd0, 5'd0, 5'd0};
    logic [6:2]  expx [6] = '{5'd4, 5'd12, 5'd0, 5'd4, 5'd5, 5'd0};
    for (int i = 0; i < 6; i++) begin
      set_e(ops[i], adrs[i], 32'h0, excs[i], 5'd7, 32'h400);
      step();
      set_e(NONE, 0, 0, 0, 0, 0);
      bus.mem_ack = 1'b1;
      #1;
      if (ExcCodeM !== expx[i]) begin
        $display("FAIL range_exc[%0d]: got %0d expected %0d", i, ExcCodeM, expx[i]); fails++;
      end
      checks++;
      if (bus.mem_req !== (expx[i] == 5'd0)) begin
        $display("FAIL range_req[%0d]: got %b expected %b", i, bus.mem_req, expx[i] == 5'd0);
        fails++;
      end
      checks++;
      if (RFWA_M !== ((expx[i] == 5'd0) ? 5'd7 : 5'd0)) begin
        $display("FAIL range_rfwa[%0d]: got %0d", i, RFWA_M); fails++;
      end
      checks++;
      step();
      bus.mem_ack = 1'b0;
    end
  endtask

  task automatic test_flush_busy();
    set_e(LW, 32'h20, 32'h0, 5'd0, 5'd5, 32'h200);
    step();
    set_e(LW, 32'h40, 32'h0, 5'd0, 5'd9, 32'h300);
    #1;
    if (busy !== 1'b1) begin $display("FAIL flush_busy_c1: got %b expected 1", busy); fails++; end
    checks++;
    step();
    flush = 1'b1;
    #1;
    if (busy !== 1'b1 || C_M !== 32'h20) begin
      $display("FAIL flush_busy_c2: busy=%b C_M=%h expected 1/00000020", busy, C_M); fails++;
    end
    checks++;
    step();
    flush = 1'b0;
    #1;
    if (busy !== 1'b1 || PC_M !== 32'h200) begin
      $display("FAIL flush_busy_c3: busy=%b PC_M=%h expected 1/00000200", busy, PC_M); fails++;
    end
    checks++;
    step();
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h1111_2222;
    #1;
    if (busy !== 1'b0 || RFWA_M !== 5'd0 || LD_M !== 32'h0) begin
      $display("FAIL flush_ack_discard: busy=%b rfwa=%0d LD_M=%h expected 0/0/0", busy, RFWA_M, LD_M);
      fails++;
    end
    checks++;
    step();
    bus.mem_ack = 1'b0;
    #1;
    if (C_M !== 32'h0 || PC_M !== 32'h0 || bus.mem_req !== 1'b0 || RFWA_M !== 5'd0) begin
      $display("FAIL flush_bubble: C_M=%h PC_M=%h req=%b rfwa=%0d expected 0/0/0/0", C_M, PC_M,
               bus.mem_req, RFWA_M);
      fails++;
    end
    checks++;
    step();
    set_e(NONE, 0, 0, 0, 0, 0);
    bus.mem_ack = 1'b1;
    #1;
    if (bus.mem_req !== 1'b1 || C_M !== 32'h40 || RFWA_M !== 5'd9 || bus.mem_addr !== 32'h40) begin
      $display("FAIL flush_resume: req=%b C_M=%h rfwa=%0d addr=%h expected 1/00000040/9/00000040",
               bus.mem_req, C_M, RFWA_M, bus.mem_addr);
      fails++;
    end
    checks++;
    step();
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_stall();
    set_e(LW, 32'h10, 32'h0, 5'd0, 5'd2, 32'h700);
    step();
    set_e(LW, 32'h24, 32'h0, 5'd0, 5'd6, 32'h704);
    stall = 1'b1;
    bus.mem_ack = 1'b1;
    #1;
    if (bus.mem_req !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL stall_first: req=%b busy=%b expected 1/0", bus.mem_req, busy); fails++;
    end
    checks++;
    step();
    bus.mem_ack = 1'b0;
    #1;
    if (C_M !== 32'h10 || PC_M !== 32'h700 || bus.mem_req !== 1'b0) begin
      $display("FAIL stall_hold: C_M=%h PC_M=%h req=%b expected 00000010/00000700/0", C_M, PC_M,
               bus.mem_req);
      fails++;
    end
    checks++;
    stall = 1'b0;
    step();
    set_e(NONE, 0, 0, 0, 0, 0);
    bus.mem_ack = 1'b1;
    #1;
    if (C_M !== 32'h24 || bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h24) begin
      $display("FAIL stall_release: C_M=%h req=%b addr=%h expected 00000024/1/00000024", C_M,
               bus.mem_req, bus.mem_addr);
      fails++;
    end
    checks++;
    step();
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    set_e(SW, 32'h100, 32'h55AA_55AA, 5'd0, 5'd0, 32'h500);
    step();
    set_e(NONE, 0, 0, 0, 0, 0);
    bus.mem_ack = 1'b0;
    #1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy !== 1'b1) break;
      n++;
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h100 ||
          bus.mem_be !== 4'b1111 || bus.mem_wdata !== 32'h55AA_55AA) begin
        $display("FAIL timeout_stable[%0d]: req=%b we=%b addr=%h be=%b wdata=%h", i, bus.mem_req,
                 bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata);
        fails++;
      end
      checks++;
      step();
    end
    if (n !== 16) begin $display("FAIL timeout_busy_cycles: got %0d expected 16", n); fails++; end
    checks++;
    if (ExcCodeM !== 5'd7 || bus.mem_req !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL timeout_dbe: exc=%0d req=%b busy=%b expected 7/0/0", ExcCodeM, bus.mem_req, busy);
      fails++;
    end
    checks++;
    stall = 1'b1;
    step();
    if (ExcCodeM !== 5'd7 || bus.mem_req !== 1'b0) begin
      $display("FAIL timeout_stall_hold: exc=%0d req=%b expected 7/0", ExcCodeM, bus.mem_req);
      fails++;
    end
    checks++;
    stall = 1'b0;
    step();
    if (ExcCodeM !== 5'd0) begin
      $display("FAIL timeout_clear: exc=%0d expected 0", ExcCodeM); fails++;
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    set_e(SW, 32'h8, 32'hCAFE_F00D, 5'd0, 5'd0, 32'h600);
    step();
    set_e(NONE, 0, 0, 0, 0, 0);
    #1;
    if (bus.mem_req !== 1'b1) begin
      $display("FAIL reset_mid_req: got %b expected 1", bus.mem_req); fails++;
    end
    checks++;
    reset = 1'b0;
    #1;
    if ({busy, bus.mem_req, bus.mem_we, bus.mem_be, ExcCodeM, RFWA_M} !== '0 ||
        {C_M, PC_M, LD_M, bus.mem_addr, bus.mem_wdata} !== '0) begin
      $display("FAIL reset_mid_outputs: req=%b busy=%b C_M=%h PC_M=%h wdata=%h expected all zero",
               bus.mem_req, busy, C_M, PC_M, bus.mem_wdata);
      fails++;
    end
    checks++;
    step();
    reset = 1'b1;
    step();
    if (bus.mem_req !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL reset_mid_idle: req=%b busy=%b expected 0/0", bus.mem_req, busy); fails++;
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_range();
    test_flush_busy();
    test_stall();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
